lut_interp: RTL
===============

# lut_interp

Pipelined piecewise-linear interpolator that reads an activation-function lookup table. It sits between an LSTM layer's accumulator output and the activation LUT. For each input it splits the signed fixed-point operand into a table address and a fraction, and drives the address to the LUT. It takes the segment endpoints returned by the LUT (`base`, `next__data`) and emits base + slope·fraction, using a valid/ready handshake on both sides.

## Interface
- `DATA_W`, 8: width of the input operand, the LUT entries and the output.
- `ADDR_W`, 4: LUT address width; the fraction width is `FRAC_W = DATA_W - ADDR_W`.
- `clk`  in  1  Sole clock; every register updates on its rising edge.
- `rst`  in  1  Reset; synchronous and active-low.
- `in_valid`  in  1  Input sample present.
- `in_ready`  out  1  Block accepts an input this cycle.
- `in_data`  in  DATA_W  Signed operand.
- `lut_address`  out  ADDR_W  Registered address to the LUT.
- `lut_base`  in  DATA_W  Signed LUT entry at `lut_address` (combinational from the LUT).
- `lut_next`  in  DATA_W  Signed next entry, including the LUT's own wrap/clamp rules.
- `out_valid`  out  1  Result present.
- `out_ready`  in  1  Downstream accepts the result.
- `out_data`  out  DATA_W  Signed interpolated result.

## Operation
- Address and fraction:
  - `address = in_data[DATA_W-1:FRAC_W]` (raw two's-complement bits, so 0..7 are positive and 8..15 negative).
  - `frac = in_data[FRAC_W-1:0]`, unsigned.
- Four register stages, each with its own valid bit:
  - **A**: captures address and frac; `lut_address` is driven from A.
  - **B**: captures `lut_base`, `lut_next` and frac.
  - **C**: computes `diff = next - base` (DATA_W+1 bits, signed) and `prod = diff * {1'b0,frac}` (DATA_W+FRAC_W+2 bits, signed); registers `prod` and `base`.
  - **D** (output register): `out_data = base + (prod >>> FRAC_W)`, with an arithmetic shift, truncated to DATA_W bits.
- Truncation in stage D is lossless: the result always lies between `base` and `next`, with or without rounding.
- Global advance: `adv = !out_valid || out_ready`.
  - When `adv` is high, all stages shift by one and stage A loads `in_valid`.
  - When `adv` is low, every stage holds, including bubbles. `lut_address` and `out_data` stay stable.
- `in_ready = adv`. This is combinational from `out_ready` and the `out_valid` register; no other combinational path runs input to output.
- A transfer occurs when `in_valid && in_ready` is high at a rising edge, and likewise for `out_valid && out_ready`.
- No reordering, dropping or duplication of samples.
- Reset (`rst`=0 at a rising edge) gives:
  - all valid bits 0, so `out_valid`=0;
  - `out_data`=0, `lut_address`=0 and all datapath registers 0;
  - `in_ready`=1 after the edge.
- Reset mid-stream discards all in-flight samples; no result for them is ever emitted.
- Reset takes priority over the handshake at the same edge.

## Timing
- Latency: a sample accepted at rising edge N gives `out_valid`=1 with its result after edge N+3, provided there is no stall.
- Throughput: one sample per cycle while `out_ready`=1.
- Backpressure: if `out_valid`=1 and `out_ready`=0, then `in_ready`=0 in the same cycle and the pipeline freezes.
- When `out_ready` returns to 1, the held result transfers at that edge and the pipeline advances at the same edge.
- `lut_base` and `lut_next` are sampled one cycle after `lut_address` changes. The LUT must be purely combinational.
- Pipeline capacity is four samples.

## Configuration
- `LUT_INTERP_ROUND_EN`, defined: stage D computes `(prod + 2^(FRAC_W-1)) >>> FRAC_W`, i.e. round half up.
- `LUT_INTERP_ROUND_EN`, undefined: stage D computes `prod >>> FRAC_W`, i.e. floor.
- Latency and interface are identical in both builds.

## Test plan
- **Reset**: hold `rst`=0 for 2 cycles with `in_valid`=1 → `out_valid`=0, `out_data`=0, `lut_address`=0; `in_ready`=1 on release; no output for 5 cycles after release unless new input arrives.
- **Linear table**:
  - Bench LUT: `base` = 16·addr (signed 8-bit); `next` = base+16; addr 7 gives next=112; addr 15 gives next=0.
  - Stimulus: stream `in_data` 0x00..0xFF back-to-back with `out_ready`=1.
  - Expected: 0x00..0x6F and 0x80..0xFF return unchanged; 0x70..0x7F all return 0x70; first result appears after edge N+3; one result per cycle.
- **Rounding**:
  - `base`=0, `next`=3, frac=8 → 1 in the floor build, 2 with `LUT_INTERP_ROUND_EN`.
  - `base`=0, `next`=-3, frac=8 → -2 in the floor build, -1 with the macro.
- **Backpressure**: fill the pipeline with 4 samples, then hold `out_ready`=0 for 6 cycles → `in_ready`=0 throughout; `out_data` and `lut_address` stable; on release all 4 results drain in order with no loss or duplication.
- **Bubbles**: input pattern `in_valid` 1,0,1,1,0,1 → `out_valid` shows the same pattern delayed 3 edges, with matching data.
- **Mid-stream reset**: assert `rst`=0 for 1 cycle while 3 samples are in flight → none of them is ever output; the next accepted sample appears with nominal latency.

Source files
------------

// File: rtl/lut_interp_if.sv
// lut_interp_if -- handshake and LUT bus of the lut_interp interpolator.
//
// Signals:
//   in_valid / in_ready / in_data        upstream operand handshake
//   lut_address / lut_base / lut_next    activation LUT read port
//   out_valid / out_ready / out_data     downstream result handshake
// Modports:
//   slave  : the interpolator itself
//   master : the environment (upstream source, LUT and downstream sink)
interface lut_interp_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] lut_address;
  logic [DATA_W-1:0] lut_base;
  logic [DATA_W-1:0] lut_next;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, lut_base, lut_next, out_ready,
    output in_ready, lut_address, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, lut_base, lut_next, out_ready,
    input  in_ready, lut_address, out_valid, out_data
  );
endinterface

// File: rtl/lut_interp.sv
// lut_interp -- four-stage piecewise-linear interpolator in front of an
// activation LUT. The signed operand is split into a table address (upper
// ADDR_W bits) and an unsigned fraction (lower FRAC_W bits); the result is
// base + (next - base) * frac / 2^FRAC_W.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-low reset
//   bus   lut_interp_if.slave: input handshake, LUT read port, output handshake
//
// Build option:
//   LUT_INTERP_ROUND_EN  defined   -> final shift rounds half up
//                        undefined -> final shift floors
//
// Stages: A (address/frac, drives lut_address), B (LUT data), C (product),
// D (output register). One global advance freezes all stages, bubbles
// included, while a result is waiting on out_ready.
module lut_interp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input logic         clk,
  input logic         rst,
  lut_interp_if.slave bus
);
  localparam int FRAC_W = DATA_W - ADDR_W;
  localparam int DIFF_W = DATA_W + 1;
  localparam int PROD_W = DATA_W + FRAC_W + 2;

`ifdef LUT_INTERP_ROUND_EN
  localparam logic [PROD_W-1:0] RND_C = {{(PROD_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);
`endif

  // Stage registers and their next-state values
  logic              a_valid_q, a_valid_d;
  logic [ADDR_W-1:0] a_addr_q,  a_addr_d;
  logic [FRAC_W-1:0] a_frac_q,  a_frac_d;
  logic              b_valid_q, b_valid_d;
  logic [DATA_W-1:0] b_base_q,  b_base_d;
  logic [DATA_W-1:0] b_next_q,  b_next_d;
  logic [FRAC_W-1:0] b_frac_q,  b_frac_d;
  logic              c_valid_q, c_valid_d;
  logic [PROD_W-1:0] c_prod_q,  c_prod_d;
  logic [DATA_W-1:0] c_base_q,  c_base_d;
  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] d_data_q,  d_data_d;

  // Combinational datapath
  logic              adv;
  logic [DIFF_W-1:0] diff;
  logic [PROD_W-1:0] diff_x;
  logic [PROD_W-1:0] frac_x;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] prod_adj;
  logic [PROD_W-1:0] prod_sh;
  logic [DATA_W-1:0] d_sum;
  logic              unused_prod_hi;

  // Global advance: the whole pipe moves unless a result is stuck downstream
  always_comb begin
    adv = ~d_valid_q | bus.out_ready;
  end

  // Stage C arithmetic: sign-extended difference times zero-extended fraction.
  // Both operands are widened to the product width, so the modular product
  // equals the signed product.
  always_comb begin
    diff   = {b_next_q[DATA_W-1], b_next_q} - {b_base_q[DATA_W-1], b_base_q};
    diff_x = {{(PROD_W-DIFF_W){diff[DIFF_W-1]}}, diff};
    frac_x = {{(PROD_W-FRAC_W){1'b0}}, b_frac_q};
    prod   = diff_x * frac_x;
  end

  // Stage D arithmetic: scale the product back down and add the base. The
  // scaled step never leaves the [base, next] range, so keeping only the low
  // DATA_W bits loses nothing.
  always_comb begin
`ifdef LUT_INTERP_ROUND_EN
    prod_adj = c_prod_q + RND_C;
`else
    prod_adj = c_prod_q;
`endif
    prod_sh        = $signed(prod_adj) >>> FRAC_W;
    d_sum          = c_base_q + prod_sh[DATA_W-1:0];
    unused_prod_hi = ^prod_sh[PROD_W-1:DATA_W];
  end

  // Next-state selection: shift every stage on advance, otherwise hold all
  always_comb begin
    if (adv) begin
      a_valid_d = bus.in_valid;
      a_addr_d  = bus.in_data[DATA_W-1:FRAC_W];
      a_frac_d  = bus.in_data[FRAC_W-1:0];
      b_valid_d = a_valid_q;
      b_base_d  = bus.lut_base;
      b_next_d  = bus.lut_next;
      b_frac_d  = a_frac_q;
      c_valid_d = b_valid_q;
      c_prod_d  = prod;
      c_base_d  = b_base_q;
      d_valid_d = c_valid_q;
      d_data_d  = d_sum;
    end else begin
      a_valid_d = a_valid_q;
      a_addr_d  = a_addr_q;
      a_frac_d  = a_frac_q;
      b_valid_d = b_valid_q;
      b_base_d  = b_base_q;
      b_next_d  = b_next_q;
      b_frac_d  = b_frac_q;
      c_valid_d = c_valid_q;
      c_prod_d  = c_prod_q;
      c_base_d  = c_base_q;
      d_valid_d = d_valid_q;
      d_data_d  = d_data_q;
    end
  end

  // Pipeline registers; reset wins over any handshake on the same edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_valid_q <= 1'b0;
      a_addr_q  <= {ADDR_W{1'b0}};
      a_frac_q  <= {FRAC_W{1'b0}};
      b_valid_q <= 1'b0;
      b_base_q  <= {DATA_W{1'b0}};
      b_next_q  <= {DATA_W{1'b0}};
      b_frac_q  <= {FRAC_W{1'b0}};
      c_valid_q <= 1'b0;
      c_prod_q  <= {PROD_W{1'b0}};
      c_base_q  <= {DATA_W{1'b0}};
      d_valid_q <= 1'b0;
      d_data_q  <= {DATA_W{1'b0}};
    end else begin
      a_valid_q <= a_valid_d;
      a_addr_q  <= a_addr_d;
      a_frac_q  <= a_frac_d;
      b_valid_q <= b_valid_d;
      b_base_q  <= b_base_d;
      b_next_q  <= b_next_d;
      b_frac_q  <= b_frac_d;
      c_valid_q <= c_valid_d;
      c_prod_q  <= c_prod_d;
      c_base_q  <= c_base_d;
      d_valid_q <= d_valid_d;
      d_data_q  <= d_data_d;
    end
  end

  // in_ready is the only combinational input-to-output path
  assign bus.in_ready    = adv;
  assign bus.lut_address = a_addr_q;
  assign bus.out_valid   = d_valid_q;
  assign bus.out_data    = d_data_q;
endmodule
